alt_vipvfr130_common_unpack_stream: RTL and testbench
=====================================================

# alt_vipvfr130_common_unpack_stream

Parametrised stream unpacker between the frame-reader memory master and the pixel pipeline. It takes wide memory words and emits narrower pixel words LSB-first with valid/ready handshakes on both sides. Any `IN_WIDTH >= OUT_WIDTH` ratio is supported; residual bits carry across input words. A synchronous `clear` discards buffered residue, and an optional line-length counter marks the last pixel of each line and drops padding automatically.

## Interface
- `IN_WIDTH`, default 128: memory-side word width. Must satisfy `IN_WIDTH >= OUT_WIDTH`; checked by elaboration assertion.
- `OUT_WIDTH`, default 24: pixel width. Must be ≥ 1.
- `LINE_W`, default 16: width of `line_length` (used only with `UNPACK_EOL_EN`).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `din` in IN_WIDTH: memory word.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: unpacker accepts `din` this cycle.
- `dout` out OUT_WIDTH: pixel.
- `dout_valid` out 1: `dout` is valid.
- `dout_ready` in 1: downstream accepts `dout`.
- `clear` in 1: discard all buffered bits.
- `line_length` in LINE_W: pixels per line (`UNPACK_EOL_EN` only).
- `dout_last` out 1: current pixel is the last of its line (`UNPACK_EOL_EN` only).

## Operation
- **Storage.**
  - Buffer register `buf`, width `BUF_W = IN_WIDTH + OUT_WIDTH - 1`.
  - Fill counter `count`, range 0..BUF_W.
- **Output.**
  - `dout = buf[OUT_WIDTH-1:0]`.
  - `dout_valid = (count >= OUT_WIDTH) & ~clear`.
- **Pop** (`dout_valid & dout_ready`): `buf` shifts right by OUT_WIDTH; `count -= OUT_WIDTH`.
- **Accept.**
  - `din_ready = (count_after_pop < OUT_WIDTH) & ~clear`, where `count_after_pop` is `count` minus OUT_WIDTH if a pop occurs this cycle.
  - `din_ready` depends combinationally on `dout_ready`.
- **Push** (`din_valid & din_ready`): `din` is written at bit offset `count_after_pop`; `count = count_after_pop + IN_WIDTH`. Bits above the new count are don't-care.
- **Simultaneous pop and push** in one cycle is required, giving full throughput. With `IN_WIDTH == OUT_WIDTH` the block sustains one word per cycle.
- **Clear.** `clear` forces `dout_valid` and `din_ready` low, so nothing transfers. Next cycle `count = 0`. Clear has priority over pop and push.
- **Bit ordering.** The lowest-order valid bit is emitted first. Residue from word N sits below the bits of word N+1.
- **Empty.** With `count < OUT_WIDTH`, no output is produced regardless of `dout_ready`.
- **Full.** With `count >= OUT_WIDTH` and no pop, `din_ready = 0`.

## Timing
- **Reset:** `count = 0` and line counter = 0. Therefore `dout_valid = 0`, `dout_last = 0`, `din_ready = 1` in the first cycle after reset. `dout` is don't-care.
- **Reset mid-operation:** all buffered data is lost; behaviour is identical to power-up reset.
- **Latency:** a word accepted at edge k produces `dout_valid = 1` during cycle k+1, i.e. one cycle.
- **Output stability:** `dout` and `dout_valid` are held stable while `dout_valid & ~dout_ready`. The one exception is `clear`.
- **Per-word output:** for IN=128, OUT=24, each word yields 5 pixels. The 8-bit residue combines with the next word.

## Configuration
- **`UNPACK_EOL_EN` defined:**
  - `line_length` and `dout_last` ports exist.
  - A pixel counter `pix_cnt` increments on each pop.
  - `dout_last = dout_valid & (pix_cnt == line_length - 1)`.
  - Popping a pixel with `dout_last` high resets `pix_cnt` to 0. It also discards the remaining buffer (`count = 0`) in the same edge, exactly as `clear`, which drops end-of-line padding bits.
  - A push in that same cycle is refused: `din_ready = 0` when popping a last pixel.
  - `line_length` is sampled every cycle; it must be held constant within a line.
  - `line_length == 0` disables last-marking and auto-discard.
  - `clear` and `reset` also zero `pix_cnt`.
- **`UNPACK_EOL_EN` undefined:** neither port exists; the line counter logic is not instantiated.

## Structure
- **Package `alt_vipvfr130_common_unpack_pkg`:**
  - function `unpack_buf_w(in_w, out_w)` returning `in_w + out_w - 1`.
  - function `unpack_cnt_w(in_w, out_w)` returning `$clog2(in_w + out_w)`.
- **Sub-module `alt_vipvfr130_common_unpack_line_counter`:**
  - Holds the `pix_cnt` register and the `dout_last` compare.
  - Instantiated only under `UNPACK_EOL_EN`.

## Test plan
- **Non-integer ratio:** IN=32, OUT=24, words 0x44332211, 0x88776655, 0xCCBBAA99 with `dout_ready = 1` → pixels 0x332211, 0x665544, 0x998877, 0xCCBBAA in order; `dout_valid` low afterwards.
- **Back-pressure:** same stimulus with `dout_ready` low for 5 cycles after the first pixel → `dout` held at 0x665544 throughout, `din_ready = 0`, no data loss.
- **Clear:** IN=32, OUT=24; after the first pixel, pulse `clear` → next cycle `dout_valid = 0` and `din_ready = 1`. Next word 0x00FFEEDD → pixel 0xFFEEDD, with no residue from before the clear.
- **Full rate and reset:** IN=OUT=24, continuous random input with `dout_ready = 1` → one pixel per cycle matching input, 1-cycle latency. Reset asserted mid-stream → `dout_valid = 0` next cycle.
- **End of line (`UNPACK_EOL_EN`):** IN=32, OUT=24, `line_length = 3` on the same three words → `dout_last` on 0x998877. The 0xCCBBAA residue is discarded; the next line starts at the next word.
- **IN=128, OUT=24 stress:** a constrained-random valid/ready pattern is compared against a reference bit-queue model; no mismatches over 10 000 pixels.

Source files
------------

// File: rtl/alt_vipvfr130_common_unpack_pkg.sv
// Shared sizing helpers for the stream unpacker.
// The buffer must hold one full input word on top of the largest residue
// that can remain while the unpacker still accepts input (OUT_WIDTH-1 bits).
package alt_vipvfr130_common_unpack_pkg;

    // Width of the residue-plus-word buffer.
    function automatic int unpack_buf_w(input int in_w, input int out_w);
        return in_w + out_w - 1;
    endfunction

    // Width of a fill counter able to represent 0..unpack_buf_w().
    function automatic int unpack_cnt_w(input int in_w, input int out_w);
        return $clog2(in_w + out_w);
    endfunction

endpackage

// File: rtl/alt_vipvfr130_common_unpack_line_counter.sv
// Per-line pixel counter for the stream unpacker.
// Counts popped pixels and flags the last pixel of each line; a line length
// of zero disables the flag entirely.
module alt_vipvfr130_common_unpack_line_counter
    import alt_vipvfr130_common_unpack_pkg::*;
#(
    parameter int LINE_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              dout_valid,
    input  logic              pop,
    input  logic [LINE_W-1:0] line_length,
    output logic              dout_last
);

    logic [LINE_W-1:0] pix_cnt;

    // The pixel on the output is the last of its line when the count reaches line_length-1.
    always_comb begin
        dout_last = dout_valid & (line_length != '0) &
                    (pix_cnt == (line_length - LINE_W'(1)));
    end

    // Advance on every pop; restart after the last pixel, on clear and on reset.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pix_cnt <= '0;
        end else if (pop) begin
            if (dout_last) begin
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_cnt + LINE_W'(1);
            end
        end
    end

endmodule

// File: rtl/alt_vipvfr130_common_unpack_stream.sv
// Stream unpacker: wide memory words in, narrow pixels out, LSB first.
// Residue bits of one word sit below the bits of the next word.
// Optional feature macro: UNPACK_EOL_EN adds line_length/dout_last, marks the
// last pixel of each line and discards the padding left after it.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. dout/dout_valid stay stable while dout_valid & ~dout_ready
// (except when clear is asserted). din_ready depends combinationally on
// dout_ready so a pop and a push can share one cycle (full throughput).
module alt_vipvfr130_common_unpack_stream
    import alt_vipvfr130_common_unpack_pkg::*;
#(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 24,
    parameter int LINE_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
`ifdef UNPACK_EOL_EN
    input  logic [LINE_W-1:0]    line_length,
    output logic                 dout_last,
`endif
    input  logic                 clear
);

    localparam int BUF_W = unpack_buf_w(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W = unpack_cnt_w(IN_WIDTH, OUT_WIDTH);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_WIDTH);

    // Parameter sanity checks at elaboration.
    if (OUT_WIDTH < 1) begin : g_bad_out_width
        $error("OUT_WIDTH must be at least 1");
    end
    if (IN_WIDTH < OUT_WIDTH) begin : g_bad_ratio
        $error("IN_WIDTH must be greater than or equal to OUT_WIDTH");
    end
    if (LINE_W < 1) begin : g_bad_line_w
        $error("LINE_W must be at least 1");
    end

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    logic [BUF_W-1:0] buf_after_pop;
    logic [BUF_W-1:0] keep_mask;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_after_pop;
    logic             pop;
    logic             push;
    logic             line_last;
    logic             pop_last;

`ifdef UNPACK_EOL_EN
    alt_vipvfr130_common_unpack_line_counter #(
        .LINE_W(LINE_W)
    ) u_line_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .dout_valid (dout_valid),
        .pop        (pop),
        .line_length(line_length),
        .dout_last  (line_last)
    );
    assign dout_last = line_last;
`else
    assign line_last = 1'b0;
`endif

    assign dout = buf_q[OUT_WIDTH-1:0];

    // Handshakes, shift-out of the popped pixel and insertion of a new word above the residue.
    always_comb begin
        dout_valid      = (count_q >= OUT_CNT) & ~clear;
        pop             = dout_valid & dout_ready;
        pop_last        = pop & line_last;
        count_after_pop = pop ? (count_q - OUT_CNT) : count_q;
        din_ready       = (count_after_pop < OUT_CNT) & ~clear & ~pop_last;
        push            = din_valid & din_ready;

        buf_after_pop   = pop ? (buf_q >> OUT_WIDTH) : buf_q;
        keep_mask       = ~({BUF_W{1'b1}} << count_after_pop);
        buf_d           = buf_after_pop;
        if (push) begin
            buf_d = (buf_after_pop & keep_mask) | (BUF_W'(din) << count_after_pop);
        end

        count_d = count_after_pop;
        if (clear || pop_last) begin
            count_d = '0;
        end else if (push) begin
            count_d = count_after_pop + IN_CNT;
        end
    end

    // Fill count is the only control state; reset empties the buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Data buffer: contents above the fill count are don't-care, so no reset.
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_alt_vipvfr130_common_unpack_stream.sv
// Bench for the stream unpacker: three instances (32->24, 24->24, 128->24)
// checked every cycle against a bit-queue model, plus directed literal checks.
module tb_alt_vipvfr130_common_unpack_stream;

    localparam int NI = 3;
    localparam int OW = 24;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus and DUT signals ----------------
    logic [127:0] din        [NI];
    logic         din_valid  [NI];
    logic         dout_ready [NI];
    logic         clr        [NI];
    logic         rst        [NI];
    logic [15:0]  ll         [NI];

    logic         dr_a [NI];
    logic         dv_a [NI];
    logic [OW-1:0] do_a [NI];
    logic         dl_a [NI];

    logic dr0, dr1, dr2, dv0, dv1, dv2;
    logic [OW-1:0] do0, do1, do2;
`ifdef UNPACK_EOL_EN
    logic dl0, dl1, dl2;
`endif

    alt_vipvfr130_common_unpack_stream #(.IN_WIDTH(32), .OUT_WIDTH(24), .LINE_W(16)) u0 (
        .clock(clk), .reset(rst[0]), .din(din[0][31:0]), .din_valid(din_valid[0]),
        .din_ready(dr0), .dout(do0), .dout_valid(dv0), .dout_ready(dout_ready[0]),
`ifdef UNPACK_EOL_EN
        .line_length(ll[0]), .dout_last(dl0),
`endif
        .clear(clr[0])
    );

    alt_vipvfr130_common_unpack_stream #(.IN_WIDTH(24), .OUT_WIDTH(24), .LINE_W(16)) u1 (
        .clock(clk), .reset(rst[1]), .din(din[1][23:0]), .din_valid(din_valid[1]),
        .din_ready(dr1), .dout(do1), .dout_valid(dv1), .dout_ready(dout_ready[1]),
`ifdef UNPACK_EOL_EN
        .line_length(ll[1]), .dout_last(dl1),
`endif
        .clear(clr[1])
    );

    alt_vipvfr130_common_unpack_stream #(.IN_WIDTH(128), .OUT_WIDTH(24), .LINE_W(16)) u2 (
        .clock(clk), .reset(rst[2]), .din(din[2]), .din_valid(din_valid[2]),
        .din_ready(dr2), .dout(do2), .dout_valid(dv2), .dout_ready(dout_ready[2]),
`ifdef UNPACK_EOL_EN
        .line_length(ll[2]), .dout_last(dl2),
`endif
        .clear(clr[2])
    );

    always_comb begin
        dr_a[0] = dr0; dr_a[1] = dr1; dr_a[2] = dr2;
        dv_a[0] = dv0; dv_a[1] = dv1; dv_a[2] = dv2;
        do_a[0] = do0; do_a[1] = do1; do_a[2] = do2;
`ifdef UNPACK_EOL_EN
        dl_a[0] = dl0; dl_a[1] = dl1; dl_a[2] = dl2;
`else
        dl_a[0] = 1'b0; dl_a[1] = 1'b0; dl_a[2] = 1'b0;
`endif
    end

    function automatic int iw(input int i);
        case (i)
            0: return 32;
            1: return 24;
            default: return 128;
        endcase
    endfunction

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue of buffered bits ----------------
    bit  mq     [NI][$];
    int  pix    [NI];
    bit  live   [NI];
    bit  m_pop  [NI];
    bit  m_push [NI];
    bit  m_last [NI];
    int  pops   [NI];
    logic [OW-1:0] out_log  [NI][$];
    bit            last_log [NI][$];

    // Compare DUT outputs with the model mid-cycle and decide this cycle's transfers.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int sz;
            int cap;
            bit ev, er, el;
            logic [OW-1:0] e;
            m_pop[i] = 1'b0; m_push[i] = 1'b0; m_last[i] = 1'b0;
            if (live[i] && !rst[i]) begin
                sz = mq[i].size();
                ev = (sz >= OW) && !clr[i];
                el = 1'b0;
`ifdef UNPACK_EOL_EN
                el = ev && (ll[i] != 16'd0) && (pix[i] == int'(ll[i]) - 1);
`endif
                m_pop[i] = ev && dout_ready[i];
                cap = m_pop[i] ? sz - OW : sz;
                er = (cap < OW) && !clr[i] && !(m_pop[i] && el);
                m_push[i] = din_valid[i] && er;
                m_last[i] = el;
                chk($sformatf("u%0d_dout_valid", i), 128'(dv_a[i]), 128'(ev));
                chk($sformatf("u%0d_din_ready", i), 128'(dr_a[i]), 128'(er));
                chk($sformatf("u%0d_dout_last", i), 128'(dl_a[i]), 128'(el));
                if (ev) begin
                    e = '0;
                    for (int b = 0; b < OW; b++) e[b] = mq[i][b];
                    chk($sformatf("u%0d_dout", i), 128'(do_a[i]), 128'(e));
                end
                if (m_pop[i]) begin
                    out_log[i].push_back(do_a[i]);
                    last_log[i].push_back(dl_a[i]);
                end
            end
        end
    end

    // Advance the model at the clock edge using the transfers decided above.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                mq[i].delete();
                pix[i] = 0;
                live[i] = 1'b1;
            end else if (live[i]) begin
                if (clr[i]) begin
                    mq[i].delete();
                    pix[i] = 0;
                end else begin
                    if (m_pop[i]) begin
                        pops[i]++;
                        repeat (OW) void'(mq[i].pop_front());
                        if (m_last[i]) begin
                            mq[i].delete();
                            pix[i] = 0;
                        end else begin
                            pix[i]++;
                        end
                    end
                    if (m_push[i]) begin
                        for (int b = 0; b < iw(i); b++) mq[i].push_back(din[i][b]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted (bounded wait).
    task automatic drive_word(input int i, input logic [127:0] w);
        bit acc;
        acc = 1'b0;
        din[i] = w;
        din_valid[i] = 1'b1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = dr_a[i];
            step();
        end
        din_valid[i] = 1'b0;
        chk($sformatf("u%0d_accept_in_time", i), 128'(acc), 128'd1);
    endtask

    // Empty the instance with a one-cycle clear and forget logged pixels.
    task automatic flush(input int i);
        clr[i] = 1'b1;
        step();
        clr[i] = 1'b0;
        step();
        out_log[i].delete();
        last_log[i].delete();
    endtask

    task automatic check_log(input int i, input string name, input logic [OW-1:0] exp_q[$]);
        chk({name, "_count"}, 128'(out_log[i].size()), 128'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < out_log[i].size(); k++) begin
            chk($sformatf("%s_px%0d", name, k), 128'(out_log[i][k]), 128'(exp_q[k]));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [OW-1:0] exp_q[$];
        logic [127:0]  prev;
        int            cyc;
        bit            reached;

        for (int i = 0; i < NI; i++) begin
            din[i] = '0; din_valid[i] = 1'b0; dout_ready[i] = 1'b1;
            clr[i] = 1'b0; rst[i] = 1'b1; ll[i] = 16'd0;
            pix[i] = 0; live[i] = 1'b0; pops[i] = 0;
            m_pop[i] = 1'b0; m_push[i] = 1'b0; m_last[i] = 1'b0;
        end
        step();
        step();
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;

        // Reset state, pinned with literals.
        @(negedge clk);
        chk("reset_dout_valid", 128'(dv0), 128'd0);
        chk("reset_din_ready", 128'(dr0), 128'd1);
        chk("reset_dout_last", 128'(dl_a[0]), 128'd0);
        step();

        // Non-integer ratio, always ready.
        drive_word(0, 128'h44332211);
        drive_word(0, 128'h88776655);
        drive_word(0, 128'hCCBBAA99);
        repeat (4) step();
        @(negedge clk);
        chk("ratio_idle_valid", 128'(dv0), 128'd0);
        exp_q = '{24'h332211, 24'h665544, 24'h998877, 24'hCCBBAA};
        check_log(0, "ratio", exp_q);
        step();
        flush(0);

        // Back-pressure after the first pixel.
        fork
            begin
                drive_word(0, 128'h44332211);
                drive_word(0, 128'h88776655);
                drive_word(0, 128'hCCBBAA99);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(negedge clk);
                    seen = dv0 && dout_ready[0];
                end
                chk("bp_first_pixel_seen", 128'(seen), 128'd1);
                step();
                dout_ready[0] = 1'b0;
                for (int t = 0; t < 5; t++) begin
                    @(negedge clk);
                    chk("bp_hold_dout", 128'(do0), 128'h665544);
                    chk("bp_hold_valid", 128'(dv0), 128'd1);
                    chk("bp_din_ready", 128'(dr0), 128'd0);
                    step();
                end
                dout_ready[0] = 1'b1;
            end
        join
        repeat (4) step();
        check_log(0, "bp", exp_q);
        flush(0);

        // Clear discards residue.
        drive_word(0, 128'h44332211);
        step();
        clr[0] = 1'b1;
        @(negedge clk);
        chk("clear_valid_during", 128'(dv0), 128'd0);
        chk("clear_ready_during", 128'(dr0), 128'd0);
        step();
        clr[0] = 1'b0;
        @(negedge clk);
        chk("clear_valid_after", 128'(dv0), 128'd0);
        chk("clear_ready_after", 128'(dr0), 128'd1);
        step();
        drive_word(0, 128'h00FFEEDD);
        repeat (2) step();
        exp_q = '{24'h332211, 24'hFFEEDD};
        check_log(0, "clear", exp_q);
        flush(0);

`ifdef UNPACK_EOL_EN
        // End of line: last pixel flagged, residue dropped, next line starts fresh.
        ll[0] = 16'd3;
        drive_word(0, 128'h44332211);
        drive_word(0, 128'h88776655);
        drive_word(0, 128'hCCBBAA99);
        drive_word(0, 128'h00FFEEDD);
        repeat (3) step();
        exp_q = '{24'h332211, 24'h665544, 24'h998877, 24'hFFEEDD};
        check_log(0, "eol", exp_q);
        for (int k = 0; k < 4 && k < last_log[0].size(); k++) begin
            chk($sformatf("eol_last%0d", k), 128'(last_log[0][k]), 128'(k == 2));
        end
        flush(0);
        ll[0] = 16'd0;
        ll[2] = 16'd7;
`endif

        // Full rate, IN == OUT: one pixel per cycle, one cycle latency.
        prev = '0;
        for (int c = 0; c < 40; c++) begin
            din[1] = 128'($urandom_range(0, 32'h00FF_FFFF));
            din_valid[1] = 1'b1;
            @(negedge clk);
            if (c > 0) begin
                chk("full_rate_valid", 128'(dv1), 128'd1);
                chk("full_rate_dout", 128'(do1), prev);
            end
            prev = din[1];
            step();
        end
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        din_valid[1] = 1'b0;
        @(negedge clk);
        chk("midreset_valid", 128'(dv1), 128'd0);
        chk("midreset_ready", 128'(dr1), 128'd1);
        step();

        // Stress: 128 -> 24 with random valid/ready and rare clears.
        cyc = 0;
        while (pops[2] < 10000 && cyc < 60000) begin
            if (!(din_valid[2] && !m_push[2])) begin
                din_valid[2] = ($urandom_range(0, 99) < 70);
                din[2] = {$urandom, $urandom, $urandom, $urandom};
            end
            dout_ready[2] = ($urandom_range(0, 99) < 70);
            clr[2] = ($urandom_range(0, 499) == 0);
            step();
            cyc++;
        end
        clr[2] = 1'b0;
        din_valid[2] = 1'b0;
        reached = (pops[2] >= 10000);
        chk("stress_10000_pixels", 128'(reached), 128'd1);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
